// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state encodings (shared with the debug register map), the
// capture state enum and the width of the change-only delta field.
package trace_pkg;

   // State encodings as seen by software through state_o.
   localparam logic [1:0] STATE_IDLE      = 2'd0;
   localparam logic [1:0] STATE_ARMED     = 2'd1;
   localparam logic [1:0] STATE_TRIGGERED = 2'd2;
   localparam logic [1:0] STATE_DONE      = 2'd3;

   // Width of the inter-store delta prepended to each word in change-only mode.
   localparam int DELTA_W = 16;

   typedef enum logic [1:0] {
      IDLE      = STATE_IDLE,
      ARMED     = STATE_ARMED,
      TRIGGERED = STATE_TRIGGERED,
      DONE      = STATE_DONE
   } trace_state_e;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace buffer: one write port, one registered read port, single clock.
// Latency: read data and rd_valid appear one cycle after rd_en; write takes effect next edge.
// Backpressure: none; read-during-write to the same address returns the old word.
// Ports: clk, rst_n (read register only, array is not reset), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (holds between reads), rd_valid.
module trace_ram #(
   parameter int WIDTH      = 256,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_valid
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Non-blocking read sees the pre-write contents on a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= mem[rd_addr];
         end
      end
   end

endmodule

// File: rtl/axi_trace_capture.sv
// Circular pre/post-trigger trace capture into an inferred dual-port RAM.
// Latency: sample stored on the edge it is valid; debug read data one cycle after rd_en_i.
// Backpressure: none; samples with trace_valid_i low are dropped, capture freezes in DONE.
// Ports: trace_i/trace_valid_i sample input; arm_i/stop_i control pulses;
//        trig_mask_i/trig_value_i/post_count_i trigger setup; rd_en_i/rd_addr_i ->
//        rd_data_o/rd_valid_o debug read; state_o/wr_ptr_o/trig_ptr_o/wrapped_o/busy_o status.
// Option: define TRACE_CHANGE_ONLY_EN to store only changed samples, each tagged with a
//         16-bit delta of valid cycles since the previous store (MEM_W grows by 16).
module axi_trace_capture
   import trace_pkg::*;
#(
   parameter int TRACE_WIDTH = 256,
   parameter int DEPTH_LOG2  = 9,
   parameter int CNT_WIDTH   = DEPTH_LOG2,
`ifdef TRACE_CHANGE_ONLY_EN
   localparam int MEM_W      = TRACE_WIDTH + DELTA_W
`else
   localparam int MEM_W      = TRACE_WIDTH
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [TRACE_WIDTH-1:0] trace_i,
   input  logic                   trace_valid_i,
   input  logic                   arm_i,
   input  logic                   stop_i,
   input  logic [TRACE_WIDTH-1:0] trig_mask_i,
   input  logic [TRACE_WIDTH-1:0] trig_value_i,
   input  logic [CNT_WIDTH-1:0]   post_count_i,
   input  logic                   rd_en_i,
   input  logic [DEPTH_LOG2-1:0]  rd_addr_i,
   output logic [MEM_W-1:0]       rd_data_o,
   output logic                   rd_valid_o,
   output logic [1:0]             state_o,
   output logic [DEPTH_LOG2-1:0]  wr_ptr_o,
   output logic [DEPTH_LOG2-1:0]  trig_ptr_o,
   output logic                   wrapped_o,
   output logic                   busy_o
);

   trace_state_e          state_q, state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, trig_ptr_q, post_cnt_q, post_init;
   logic                  wrapped_q;
   logic                  active, ctl_ok, hit, trig_fire, store;
   logic [MEM_W-1:0]      wr_data;

   assign active = (state_q == ARMED) || (state_q == TRIGGERED);

   // A sample is a candidate only when capturing and no control pulse overrides it.
   assign ctl_ok    = active && trace_valid_i && !arm_i && !stop_i;
   assign hit       = ((trace_i ^ trig_value_i) & trig_mask_i) == '0;
   assign trig_fire = ctl_ok && (state_q == ARMED) && hit;

   // Clamp the post count to DEPTH-1 so the post-trigger run never reaches the trigger slot.
   always_comb begin
      if (32'(post_count_i) > 32'((1 << DEPTH_LOG2) - 1)) begin
         post_init = '1;
      end else begin
         post_init = DEPTH_LOG2'(post_count_i);
      end
   end

`ifdef TRACE_CHANGE_ONLY_EN
   logic                   first_q;
   logic [TRACE_WIDTH-1:0] last_q;
   logic [DELTA_W-1:0]     gap_q, delta;

   // The trigger sample is stored even when it repeats the previous one.
   assign store = ctl_ok && (first_q || trig_fire || (trace_i != last_q));

   // gap_q counts skipped valid cycles; the storing cycle itself adds one.
   always_comb begin
      if (first_q) begin
         delta = '0;
      end else if (gap_q == '1) begin
         delta = '1;
      end else begin
         delta = gap_q + 16'd1;
      end
   end

   assign wr_data = {delta, trace_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b1;
         last_q  <= '0;
         gap_q   <= '0;
      end else if (arm_i) begin
         first_q <= 1'b1;
         gap_q   <= '0;
      end else if (ctl_ok) begin
         if (store) begin
            first_q <= 1'b0;
            last_q  <= trace_i;
            gap_q   <= '0;
         end else if (gap_q != '1) begin
            gap_q   <= gap_q + 16'd1;
         end
      end
   end
`else
   assign store   = ctl_ok;
   assign wr_data = trace_i;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; arm_i restarts from any state and beats stop_i.
   always_comb begin
      state_d = state_q;
      if (arm_i) begin
         state_d = ARMED;
      end else begin
         case (state_q)
            ARMED: begin
               if (stop_i) begin
                  state_d = DONE;
               end else if (trig_fire) begin
                  state_d = (post_cnt_q == '0) ? DONE : TRIGGERED;
               end
            end
            TRIGGERED: begin
               if (stop_i) begin
                  state_d = DONE;
               end else if (store && (post_cnt_q == DEPTH_LOG2'(1))) begin
                  state_d = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state.
   always_comb begin
      state_o = state_q;
      busy_o  = active;
   end

   // Pointers and post-trigger counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         trig_ptr_q <= '0;
         post_cnt_q <= '0;
         wrapped_q  <= 1'b0;
      end else if (arm_i) begin
         wr_ptr_q   <= '0;
         trig_ptr_q <= '0;
         post_cnt_q <= post_init;
         wrapped_q  <= 1'b0;
      end else begin
         if (store) begin
            wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (wr_ptr_q == '1) begin
               wrapped_q <= 1'b1;
            end
         end
         if (trig_fire) begin
            trig_ptr_q <= wr_ptr_q;
         end
         if (store && (state_q == TRIGGERED)) begin
            post_cnt_q <= post_cnt_q - DEPTH_LOG2'(1);
         end
      end
   end

   assign wr_ptr_o   = wr_ptr_q;
   assign trig_ptr_o = trig_ptr_q;
   assign wrapped_o  = wrapped_q;

   trace_ram #(
      .WIDTH      (MEM_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (store),
      .wr_addr  (wr_ptr_q),
      .wr_data  (wr_data),
      .rd_en    (rd_en_i),
      .rd_addr  (rd_addr_i),
      .rd_data  (rd_data_o),
      .rd_valid (rd_valid_o)
   );

endmodule

// File: tb/tb_axi_trace_capture.sv
// Directed bench for axi_trace_capture with a read-data scoreboard.
// Latency: checks one-cycle read latency and per-edge capture behaviour.
// Backpressure: n/a.
module tb_axi_trace_capture;

   localparam int TW = 32;
   localparam int DL = 4;
   localparam int CW = 5;
`ifdef TRACE_CHANGE_ONLY_EN
   localparam int MEM_W = TW + 16;
`else
   localparam int MEM_W = TW;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [TW-1:0]   trace_i = '0;
   logic            trace_valid_i = 1'b0;
   logic            arm_i = 1'b0;
   logic            stop_i = 1'b0;
   logic [TW-1:0]   trig_mask_i = '0;
   logic [TW-1:0]   trig_value_i = '0;
   logic [CW-1:0]   post_count_i = '0;
   logic            rd_en_i = 1'b0;
   logic [DL-1:0]   rd_addr_i = '0;
   logic [MEM_W-1:0] rd_data_o;
   logic            rd_valid_o;
   logic [1:0]      state_o;
   logic [DL-1:0]   wr_ptr_o;
   logic [DL-1:0]   trig_ptr_o;
   logic            wrapped_o;
   logic            busy_o;

   int tests = 0;
   int fails = 0;
   logic [MEM_W-1:0] sb[$];

   always #5 clk = ~clk;

   axi_trace_capture #(
      .TRACE_WIDTH (TW),
      .DEPTH_LOG2  (DL),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .trace_i       (trace_i),
      .trace_valid_i (trace_valid_i),
      .arm_i         (arm_i),
      .stop_i        (stop_i),
      .trig_mask_i   (trig_mask_i),
      .trig_value_i  (trig_value_i),
      .post_count_i  (post_count_i),
      .rd_en_i       (rd_en_i),
      .rd_addr_i     (rd_addr_i),
      .rd_data_o     (rd_data_o),
      .rd_valid_o    (rd_valid_o),
      .state_o       (state_o),
      .wr_ptr_o      (wr_ptr_o),
      .trig_ptr_o    (trig_ptr_o),
      .wrapped_o     (wrapped_o),
      .busy_o        (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input logic [TW-1:0] m, input logic [TW-1:0] v, input logic [CW-1:0] p);
      trig_mask_i   = m;
      trig_value_i  = v;
      post_count_i  = p;
      trace_valid_i = 1'b0;
      arm_i         = 1'b1;
      tick();
      arm_i         = 1'b0;
   endtask

   task automatic sample(input logic [TW-1:0] val, input logic vld);
      trace_i       = val;
      trace_valid_i = vld;
      tick();
      trace_valid_i = 1'b0;
   endtask

   // Expected word is queued at request time and retired when read data returns.
   task automatic rd(input logic [DL-1:0] a, input logic [MEM_W-1:0] e);
      logic [MEM_W-1:0] exp_v;
      sb.push_back(e);
      rd_en_i   = 1'b1;
      rd_addr_i = a;
      tick();
      rd_en_i   = 1'b0;
      chk($sformatf("rd_valid@%0d", a), {63'd0, rd_valid_o}, 64'd1);
      exp_v = sb.pop_front();
      chk($sformatf("rd_data@%0d", a), 64'(rd_data_o), 64'(exp_v));
   endtask

   function automatic logic [MEM_W-1:0] word(input logic [15:0] d, input logic [TW-1:0] v);
`ifdef TRACE_CHANGE_ONLY_EN
      return {d, v};
`else
      return (d == 16'hFFFF) ? '0 : v;
`endif
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      #12;
      chk("rst_state",   64'(state_o),    64'd0);
      chk("rst_wr_ptr",  64'(wr_ptr_o),   64'd0);
      chk("rst_trig",    64'(trig_ptr_o), 64'd0);
      chk("rst_wrapped", 64'(wrapped_o),  64'd0);
      chk("rst_busy",    64'(busy_o),     64'd0);
      chk("rst_rdvalid", 64'(rd_valid_o), 64'd0);
      chk("rst_rddata",  64'(rd_data_o),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

`ifndef TRACE_CHANGE_ONLY_EN
      // Mask 0: first valid sample triggers, then three post stores.
      arm('0, '0, 5'd3);
      chk("t1_armed", 64'(state_o), 64'd1);
      chk("t1_busy",  64'(busy_o),  64'd1);
      sample(32'h100, 1'b1);
      chk("t1_trig_state", 64'(state_o), 64'd2);
      for (int i = 1; i < 10; i++) sample(32'h100 + i, 1'b1);
      chk("t1_done",    64'(state_o),    64'd3);
      chk("t1_trig",    64'(trig_ptr_o), 64'd0);
      chk("t1_wr_ptr",  64'(wr_ptr_o),   64'd4);
      chk("t1_wrapped", 64'(wrapped_o),  64'd0);
      chk("t1_busy_dn", 64'(busy_o),     64'd0);
      for (int i = 0; i < 4; i++) rd(DL'(i), MEM_W'(32'h100 + i));
      tick();
      chk("rd_valid_drop", 64'(rd_valid_o), 64'd0);
      chk("rd_data_hold",  64'(rd_data_o),  64'h103);

      // Pre-trigger wraps, trigger on 0x14 at address 4.
      arm(32'hFF, 32'h14, 5'd5);
      for (int i = 0; i < 32; i++) sample(TW'(i), 1'b1);
      chk("t2_done",    64'(state_o),    64'd3);
      chk("t2_trig",    64'(trig_ptr_o), 64'd4);
      chk("t2_wr_ptr",  64'(wr_ptr_o),   64'd10);
      chk("t2_wrapped", 64'(wrapped_o),  64'd1);
      rd(4'd4,  MEM_W'(32'h14));
      rd(4'd9,  MEM_W'(32'h19));
      rd(4'd3,  MEM_W'(32'h13));
      rd(4'd10, MEM_W'(32'h0A));

      // Post count 20 clamps to 15; trigger slot survives.
      arm('1, 32'h07, 5'd20);
      for (int i = 0; i < 33; i++) sample(TW'(i), 1'b1);
      chk("t3_done",    64'(state_o),    64'd3);
      chk("t3_trig",    64'(trig_ptr_o), 64'd7);
      chk("t3_wr_ptr",  64'(wr_ptr_o),   64'd7);
      chk("t3_wrapped", 64'(wrapped_o),  64'd1);
      rd(4'd7, MEM_W'(32'h07));
      rd(4'd6, MEM_W'(32'h16));
      rd(4'd8, MEM_W'(32'h08));
`endif

      // Stop while TRIGGERED after two post stores.
      arm('1, 32'h55, 5'd10);
      for (int i = 0; i < 8; i++) sample(32'h50 + i, 1'b1);
      chk("t4_trig_state", 64'(state_o),    64'd2);
      chk("t4_trig",       64'(trig_ptr_o), 64'd5);
      chk("t4_wr_ptr",     64'(wr_ptr_o),   64'd8);
      stop_i = 1'b1;
      sample(32'h58, 1'b1);
      stop_i = 1'b0;
      chk("t4_stop_state", 64'(state_o),  64'd3);
      chk("t4_stop_ptr",   64'(wr_ptr_o), 64'd8);
      sample(32'h59, 1'b1);
      chk("t4_frozen_ptr", 64'(wr_ptr_o), 64'd8);
      rd(4'd7, MEM_W'(32'h57));
      rd(4'd5, MEM_W'(32'h55));

      // Arm and stop together: arm wins.
      arm_i  = 1'b1;
      stop_i = 1'b1;
      tick();
      arm_i  = 1'b0;
      stop_i = 1'b0;
      chk("t4_armstop_state", 64'(state_o),  64'd1);
      chk("t4_armstop_ptr",   64'(wr_ptr_o), 64'd0);
      chk("t4_armstop_wrap",  64'(wrapped_o), 64'd0);

      // Trigger value only on invalid cycles: no trigger, only valid samples stored.
      arm('1, 32'hAA, 5'd2);
      sample(32'h01, 1'b1);
      sample(32'hAA, 1'b0);
      sample(32'h02, 1'b1);
      sample(32'hAA, 1'b0);
      sample(32'h03, 1'b1);
      chk("t5_state",  64'(state_o),  64'd1);
      chk("t5_wr_ptr", 64'(wr_ptr_o), 64'd3);
      sample(32'hAA, 1'b1);
      chk("t5_trig_state", 64'(state_o),    64'd2);
      chk("t5_trig",       64'(trig_ptr_o), 64'd3);
      stop_i = 1'b1;
      tick();
      chk("t5_stop", 64'(state_o), 64'd3);
      tick();
      stop_i = 1'b0;
      chk("t5_stop_in_done", 64'(state_o), 64'd3);

      // A,A,A,B,B,C with trigger on first sample.
      arm('0, '0, 5'd8);
      sample(32'h0A0A, 1'b1);
      sample(32'h0A0A, 1'b1);
      sample(32'h0A0A, 1'b1);
      sample(32'h0B0B, 1'b1);
      sample(32'h0B0B, 1'b1);
      sample(32'h0C0C, 1'b1);
      chk("t6_state", 64'(state_o), 64'd2);
`ifdef TRACE_CHANGE_ONLY_EN
      chk("t6_wr_ptr", 64'(wr_ptr_o), 64'd3);
      rd(4'd0, word(16'd0, 32'h0A0A));
      rd(4'd1, word(16'd3, 32'h0B0B));
      rd(4'd2, word(16'd2, 32'h0C0C));
`else
      chk("t6_wr_ptr", 64'(wr_ptr_o), 64'd6);
      rd(4'd1, word(16'd0, 32'h0A0A));
      rd(4'd3, word(16'd0, 32'h0B0B));
      rd(4'd5, word(16'd0, 32'h0C0C));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
